// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit -- registered, handshaked ALU stage between issue and writeback.
//
// One operation is accepted per cycle (in_valid & in_ready). Single-cycle ops
// land in the result register on the accepting edge; a new op can be accepted
// on the same edge a held result is consumed, so there is no bubble.
// Build option ALU_PIPE_MUL_EN adds an iterative unsigned shift-add multiplier
// (opcode 1001, WIDTH cycles). Without it, 1001 decodes as an undefined opcode.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid / in_ready        operation handshake (a, b, opcode)
//   a, b [WIDTH-1:0]           operands; shifts use b[SHW-1:0] only
//   opcode [3:0]               ADD 0 SLL 1 SLT 2 SLTU 3 XOR 4 SRL 5 OR 6 AND 7
//                              SUB 8 MUL 9 (ALU_PIPE_MUL_EN) SRA 13
//   out_valid / out_ready      result handshake
//   result, carry_flag, overflow_flag, zero_flag   registered result + flags
//   busy                       multiplier iterating
module alu_pipe_unit #(
  parameter int WIDTH = 64,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL    = 4'b1001;
  localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} state_t;
`endif

  // Returns {carry, overflow, result}. Unknown opcodes (and MUL, which is
  // handled by the iterative path) fall through to all zeros.
  function automatic logic [WIDTH+1:0] alu_op(input logic [3:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic [WIDTH:0]          ext;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    logic                    c;
    logic                    v;
    xs  = x;
    ys  = y;
    sh  = y[SHW-1:0];
    ext = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, x} + {1'b0, y};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow (a < b).
        ext = {1'b0, x} - {1'b0, y};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLL:  r = x << sh;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_XOR:  r = x ^ y;
      OP_SRL:  r = x >> sh;
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_SRA:  r = xs >>> sh;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [WIDTH+1:0] alu_res;
  logic             accept;

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]       cnt_q, cnt_d;
`endif

  assign in_ready = !rst && (state_q == S_IDLE || (state_q == S_HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    alu_res  = alu_op(opcode, a, b);
`ifdef ALU_PIPE_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (state_q == S_HOLD && out_ready) state_d = S_IDLE;
        if (accept) begin
          {carry_d, ovf_d, result_d} = alu_res;
          zero_d  = (alu_res[WIDTH-1:0] == '0);
          state_d = S_HOLD;
`ifdef ALU_PIPE_MUL_EN
          if (opcode == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end
`endif
        end
      end
`ifdef ALU_PIPE_MUL_EN
      S_MUL: begin
        // One partial product per cycle; the last iteration writes the result.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = acc_d[WIDTH-1:0];
          carry_d  = 1'b0;
          ovf_d    = |acc_d[2*WIDTH-1:WIDTH];
          zero_d   = (acc_d[WIDTH-1:0] == '0);
          state_d  = S_HOLD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  // Multiplier operands/accumulator are only meaningful in S_MUL, so only the
  // counter is reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign busy = (state_q == S_MUL);
`else
  assign busy = 1'b0;
`endif

  assign out_valid     = (state_q == S_HOLD);
  assign result        = result_q;
  assign carry_flag    = carry_q;
  assign overflow_flag = ovf_q;
  assign zero_flag     = zero_q;

endmodule

// File: tb/tb_alu_pipe_unit.sv
module tb_alu_pipe_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv64, ir64, ov64, or64, c64, o64, z64, bz64;
  logic [63:0] a64, b64, r64;
  logic [3:0]  op64;

  logic       iv8, ir8, ov8, or8, c8, o8, z8, bz8;
  logic [7:0] a8, b8, r8;
  logic [3:0] op8;

  int checks   = 0;
  int failures = 0;

  alu_pipe_unit #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .opcode(op64),
    .out_valid(ov64), .out_ready(or64),
    .result(r64), .carry_flag(c64), .overflow_flag(o64), .zero_flag(z64),
    .busy(bz64)
  );

  alu_pipe_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .opcode(op8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .carry_flag(c8), .overflow_flag(o8), .zero_flag(z8),
    .busy(bz8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic out64(input string tag, input logic [63:0] r,
                       input logic c, input logic o, input logic z);
    chk({tag, ".valid"}, {63'd0, ov64}, 64'd1);
    chk({tag, ".res"}, r64, r);
    chk({tag, ".c"}, {63'd0, c64}, {63'd0, c});
    chk({tag, ".o"}, {63'd0, o64}, {63'd0, o});
    chk({tag, ".z"}, {63'd0, z64}, {63'd0, z});
  endtask

  task automatic out8(input string tag, input logic [7:0] r,
                      input logic c, input logic o, input logic z);
    chk({tag, ".valid"}, {63'd0, ov8}, 64'd1);
    chk({tag, ".res"}, {56'd0, r8}, {56'd0, r});
    chk({tag, ".c"}, {63'd0, c8}, {63'd0, c});
    chk({tag, ".o"}, {63'd0, o8}, {63'd0, o});
    chk({tag, ".z"}, {63'd0, z8}, {63'd0, z});
  endtask

  // Present one op to the 64-bit unit for exactly one accepting edge.
  task automatic issue64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    iv64 = 1'b1; op64 = op; a64 = a; b64 = b; or64 = 1'b1;
    tick();
    iv64 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0; op64 = '0;
    iv8  = 1'b0; or8  = 1'b1; a8  = '0; b8  = '0; op8  = '0;
    tick();
    tick();

    // Reset state
    chk("rst.in_ready", {63'd0, ir64}, 64'd0);
    chk("rst.out_valid", {63'd0, ov64}, 64'd0);
    chk("rst.result", r64, 64'd0);
    chk("rst.flags", {61'd0, c64, o64, z64}, 64'd0);
    chk("rst.busy", {63'd0, bz64}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", {63'd0, ir64}, 64'd1);

    // Signed overflow on ADD
    issue64(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    out64("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // Back-to-back SUB then SRA (b[5:0]=3)
    iv64 = 1'b1; op64 = 4'b1000; a64 = 64'd5; b64 = 64'd7; or64 = 1'b1;
    tick();
    out64("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
    op64 = 4'b1101; a64 = 64'h8000_0000_0000_0000; b64 = 64'h43;
    tick();
    iv64 = 1'b0;
    out64("sra", 64'hF000_0000_0000_0000, 1'b0, 1'b0, 1'b0);

    // Stall: OR held for 3 cycles, then XOR a=b follows with no gap
    issue64(4'b0110, 64'hFFFF0000FFFF0000, 64'h00000000FFFF0000);
    iv64 = 1'b1; op64 = 4'b0100; a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'h1234_5678_9ABC_DEF0;
    or64 = 1'b0;
    #1;
    chk("stall.in_ready", {63'd0, ir64}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.valid", {63'd0, ov64}, 64'd1);
      chk("stall.res", r64, 64'hFFFF0000FFFF0000);
      chk("stall.in_ready", {63'd0, ir64}, 64'd0);
    end
    or64 = 1'b1;
    #1;
    chk("release.in_ready", {63'd0, ir64}, 64'd1);
    tick();
    iv64 = 1'b0;
    out64("xor_eq", 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("drain.out_valid", {63'd0, ov64}, 64'd0);

    // Remaining single-cycle ops and flag corners
    issue64(4'b0001, 64'd1, 64'h44);
    out64("sll", 64'h10, 1'b0, 1'b0, 1'b0);
    issue64(4'b0101, 64'h8000_0000_0000_0000, 64'h3F);
    out64("srl", 64'd1, 1'b0, 1'b0, 1'b0);
    issue64(4'b0111, 64'hF0F0, 64'hFF00);
    out64("and", 64'hF000, 1'b0, 1'b0, 1'b0);
    issue64(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    out64("slt", 64'd1, 1'b0, 1'b0, 1'b0);
    issue64(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    out64("sltu", 64'd0, 1'b0, 1'b0, 1'b1);
    issue64(4'b1000, 64'h8000_0000_0000_0000, 64'd1);
    out64("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue64(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    out64("add_carry", 64'd0, 1'b1, 1'b0, 1'b1);
    issue64(4'b1010, 64'd5, 64'd3);
    out64("undef", 64'd0, 1'b0, 1'b0, 1'b1);

`ifdef ALU_PIPE_MUL_EN
    // 3 x 5, with a waiting ADD that must be held off until the product is out
    issue64(4'b1001, 64'd3, 64'd5);
    iv64 = 1'b1; op64 = 4'b0000; a64 = 64'd9; b64 = 64'd9;
    chk("mul.busy", {63'd0, bz64}, 64'd1);
    chk("mul.valid", {63'd0, ov64}, 64'd0);
    chk("mul.in_ready", {63'd0, ir64}, 64'd0);
    repeat (63) tick();
    chk("mul.busy_last", {63'd0, bz64}, 64'd1);
    chk("mul.valid_last", {63'd0, ov64}, 64'd0);
    tick();
    chk("mul.busy_done", {63'd0, bz64}, 64'd0);
    out64("mul3x5", 64'd15, 1'b0, 1'b0, 1'b0);
    tick();
    iv64 = 1'b0;
    out64("add_after_mul", 64'd18, 1'b0, 1'b0, 1'b0);

    issue64(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    repeat (64) tick();
    out64("mul_hi", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);

    // Reset 10 cycles into a multiply
    issue64(4'b1001, 64'd3, 64'd5);
    repeat (9) tick();
    chk("mulrst.busy_before", {63'd0, bz64}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mulrst.valid", {63'd0, ov64}, 64'd0);
    chk("mulrst.busy", {63'd0, bz64}, 64'd0);
    chk("mulrst.result", r64, 64'd0);
    chk("mulrst.in_ready", {63'd0, ir64}, 64'd1);
    issue64(4'b0000, 64'd1, 64'd1);
    out64("add_after_rst", 64'd2, 1'b0, 1'b0, 1'b0);
`else
    issue64(4'b1001, 64'd3, 64'd5);
    out64("mul_undef", 64'd0, 1'b0, 1'b0, 1'b1);
    chk("mul_undef.busy", {63'd0, bz64}, 64'd0);
`endif

    // Reset while a result is held
    issue64(4'b0000, 64'd2, 64'd3);
    or64 = 1'b0;
    out64("hold_add", 64'd5, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("holdrst.valid", {63'd0, ov64}, 64'd0);
    chk("holdrst.result", r64, 64'd0);
    chk("holdrst.flags", {61'd0, c64, o64, z64}, 64'd0);
    or64 = 1'b1;

    // 8-bit build
    issue8(4'b0011, 8'h01, 8'hFF);
    out8("w8.sltu", 8'h01, 1'b0, 1'b0, 1'b0);
    issue8(4'b0010, 8'h01, 8'hFF);
    out8("w8.slt", 8'h00, 1'b0, 1'b0, 1'b1);
    issue8(4'b1111, 8'h5A, 8'h33);
    out8("w8.undef", 8'h00, 1'b0, 1'b0, 1'b1);
    issue8(4'b1101, 8'h80, 8'h0B);
    out8("w8.sra", 8'hF0, 1'b0, 1'b0, 1'b0);
    issue8(4'b0000, 8'h7F, 8'h01);
    out8("w8.add", 8'h80, 1'b0, 1'b1, 1'b0);
    tick();
    chk("w8.drain", {63'd0, ov8}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe_unit.md
# alu_pipe_unit

Parametrised, handshaked successor to the 64-bit combinational ALU. It registers operands and results behind valid/ready interfaces and supports any power-of-two datapath width. An optional iterative shift-add multiplier can be compiled in. It sits between the decode/issue stage and writeback, and can be stalled from either side.

## Interface
- WIDTH, 64, datapath width; power of two, 8..128.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode present.
- in_ready  output  1  unit accepts the operation this cycle.
- a, b  input  WIDTH  operands.
- opcode  input  4  ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, MUL 1001 (macro-gated), SRA 1101.
- out_valid  output  1  result register holds an undelivered result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- carry_flag, overflow_flag, zero_flag  output  1 each  registered flags paired with result.
- busy  output  1  multiplier iterating.

## Operation
- States: IDLE (output empty), HOLD (out_valid=1), MUL (iterating; MUL_EN builds only).
- Accept = in_valid & in_ready. in_ready = !rst & (IDLE | (HOLD & out_ready)); low in MUL.
- Single-cycle op accepted -> computed from the sampled a, b, opcode -> HOLD.
- HOLD & out_ready & !accept -> IDLE; HOLD & out_ready & accept -> stay HOLD with the new result (no bubble).
- Shifts use b[SHW-1:0]; upper bits of b are ignored. SRA replicates a[WIDTH-1].
- SLT/SLTU: result = {WIDTH-1 zeros, cmp}.
- ADD: carry = carry-out of bit WIDTH-1. SUB: carry = borrow (1 iff a < b unsigned). Overflow = signed overflow for ADD/SUB only; 0 for all other ops.
- zero_flag = (result == 0) for every op.
- Undefined opcode, including 1001 without MUL_EN: result 0, carry 0, overflow 0, zero 1; completes as a single-cycle op.
- MUL: unsigned shift-add, one partial product per cycle, WIDTH iterations, internal counter SHW+1 bits. result = low WIDTH bits of the product. overflow_flag = high half nonzero. carry 0.

## Timing
- Reset values: out_valid 0, result 0, all flags 0, busy 0, state IDLE. in_ready is 0 while rst=1 and 1 the cycle after.
- Single-cycle op accepted at edge N -> out_valid=1 after edge N; throughput 1/cycle while out_ready=1.
- MUL accepted at edge N -> busy=1 after N; out_valid=1 after edge N+WIDTH; busy=0 on the same edge.
- result/flags are stable while out_valid=1 & out_ready=0.
- rst mid-MUL or in HOLD: in-flight/pending result is discarded; all outputs return to reset values on that edge.
- in_valid during MUL is ignored; the producer must hold it until in_ready.

## Configuration
- ALU_PIPE_MUL_EN defined: MUL opcode, MUL state, iteration counter, and busy logic are built.
- Undefined: 1001 decodes as undefined (result 0, zero=1), busy tied 0, and no MUL state exists.

## Test plan
- WIDTH=64, ADD 7FFF_FFFF_FFFF_FFFF + 1, out_ready=1 -> one cycle later result 8000_0000_0000_0000, C=0, O=1, Z=0.
- SUB 5 - 7 then SRA 8000_0000_0000_0000 by b=0x43, issued back-to-back -> FFFF_FFFF_FFFF_FFFE (C=1, O=0), then F000_0000_0000_0000 on consecutive cycles; shift by b=3 because b[5:0] is used.
- out_ready=0 for 3 cycles after OR FFFF0000FFFF0000 | 00000000FFFF0000 -> result FFFF0000FFFF0000 held, in_ready=0; out_ready=1 with new XOR a=b -> next result 0, Z=1, no gap.
- MUL_EN, WIDTH=64, 3×5 -> busy for 64 cycles, then out_valid with result 15, O=0. FFFF_FFFF_FFFF_FFFF×2 -> result FFFF_FFFF_FFFF_FFFE, O=1.
- rst pulsed 10 cycles into a MUL -> next cycle out_valid=0, busy=0, result 0, in_ready=1; a fresh ADD 1+1 then returns 2.
- WIDTH=8 build: SLTU 0x01 < 0xFF -> 1; SLT 0x01 < 0xFF -> 0, Z=1; opcode 1111 -> result 0, Z=1.
